// File: rtl/lotto_pkg.sv
// rtl/lotto_pkg.sv - shared status and hint encodings for the lotto gauntlet
// Purpose: status_t and hint_t enums used by the game engine and its stage checker.
package lotto_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PLAY    = 3'd1,
    VICTORY = 3'd5,
    DOOM    = 3'd6
  } status_t;

  typedef enum logic [1:0] {
    HINT_NONE = 2'd0,
    HINT_LOW  = 2'd1,
    HINT_HIGH = 2'd2
  } hint_t;

endpackage

// File: rtl/lotto_stage_checker.sv
// rtl/lotto_stage_checker.sv - secret select and guess comparison for the current stage
// Purpose: picks the current stage's secret and compares the guess against it (unsigned).
// Ports:
//   stage_idx  in   current stage (values >= NUM_STAGES select an all-zero secret)
//   guess      in   guess value
//   hit        out  guess equals the stage secret
//   hint       out  HINT_LOW / HINT_HIGH / HINT_NONE relative to the secret
module lotto_stage_checker
  import lotto_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int GUESS_W    = 32,
  parameter int SW         = 3,
  parameter logic [NUM_STAGES*GUESS_W-1:0] SECRETS = '0
) (
  input  logic [SW-1:0]      stage_idx,
  input  logic [GUESS_W-1:0] guess,
  output logic               hit,
  output hint_t              hint
);

  logic [GUESS_W-1:0] secret;

  // Out-of-range index only occurs in VICTORY, where no guess is accepted.
  always_comb begin
    secret = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      if (stage_idx == SW'(k)) begin
        secret = SECRETS[k*GUESS_W +: GUESS_W];
      end
    end
  end

  always_comb begin
    hit  = (guess == secret);
    hint = HINT_NONE;
    if (!hit) begin
      hint = (guess < secret) ? HINT_LOW : HINT_HIGH;
    end
  end

endmodule

// File: rtl/lotto_gauntlet.sv
// rtl/lotto_gauntlet.sv - multi-stage guessing game engine
// Purpose: player clears NUM_STAGES stages in order, each within MAX_ATTEMPTS guesses.
// Optional feature: LOTTO_GAUNTLET_HINT_EN registers a low/high hint with each result.
// Ports:
//   clk, rst           clock; asynchronous active-low reset
//   start              IDLE -> PLAY at stage 0
//   guess_valid/_in    guess handshake input
//   guess_ready        high while in PLAY
//   stage_idx          current stage, NUM_STAGES once VICTORY
//   attempts_left      remaining attempts on the current stage
//   status             lotto_pkg::status_t
//   result_valid/_hit  one-cycle evaluation pulse and its hit flag
//   hint               registered hint (2'b00 when the feature is off)
module lotto_gauntlet
  import lotto_pkg::*;
#(
  parameter int NUM_STAGES   = 4,
  parameter int GUESS_W      = 32,
  parameter int MAX_ATTEMPTS = 3,
  parameter logic [NUM_STAGES*GUESS_W-1:0] SECRETS = '0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic                              guess_valid,
  input  logic [GUESS_W-1:0]                guess_in,
  output logic                              guess_ready,
  output logic [$clog2(NUM_STAGES+1)-1:0]   stage_idx,
  output logic [$clog2(MAX_ATTEMPTS+1)-1:0] attempts_left,
  output status_t                           status,
  output logic                              result_valid,
  output logic                              result_hit,
  output logic [1:0]                        hint
);

  localparam int SW = $clog2(NUM_STAGES+1);
  localparam int AW = $clog2(MAX_ATTEMPTS+1);
  localparam logic [SW-1:0] LAST_STAGE = SW'(NUM_STAGES-1);
  localparam logic [AW-1:0] MAX_A      = AW'(MAX_ATTEMPTS);

  status_t       state_q, state_d;
  logic [SW-1:0] stage_q, stage_d;
  logic [AW-1:0] att_q, att_d;
  logic          rv_q, rv_d;
  logic          rh_q, rh_d;
  hint_t         hint_q, hint_d;

  logic  chk_hit;
  hint_t chk_hint;

  lotto_stage_checker #(
    .NUM_STAGES (NUM_STAGES),
    .GUESS_W    (GUESS_W),
    .SW         (SW),
    .SECRETS    (SECRETS)
  ) u_checker (
    .stage_idx (stage_q),
    .guess     (guess_in),
    .hit       (chk_hit),
    .hint      (chk_hint)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      stage_q <= '0;
      att_q   <= MAX_A;
      rv_q    <= 1'b0;
      rh_q    <= 1'b0;
      hint_q  <= HINT_NONE;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      att_q   <= att_d;
      rv_q    <= rv_d;
      rh_q    <= rh_d;
      hint_q  <= hint_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    att_d   = att_q;
    rv_d    = 1'b0;
    rh_d    = 1'b0;
    hint_d  = hint_q;
    case (state_q)
      IDLE: begin
        // start wins over a simultaneous guess; the guess is simply dropped.
        if (start) begin
          state_d = PLAY;
          stage_d = '0;
          att_d   = MAX_A;
        end
      end
      PLAY: begin
        if (guess_valid) begin
          rv_d = 1'b1;
          rh_d = chk_hit;
`ifdef LOTTO_GAUNTLET_HINT_EN
          hint_d = chk_hint;
`endif
          if (chk_hit) begin
            // stage_idx lands on NUM_STAGES at VICTORY and is never advanced past it.
            stage_d = stage_q + SW'(1);
            if (stage_q == LAST_STAGE) begin
              state_d = VICTORY;
            end else begin
              att_d = MAX_A;
            end
          end else if (att_q <= AW'(1)) begin
            state_d = DOOM;
            att_d   = '0;
          end else begin
            att_d = att_q - AW'(1);
          end
        end
      end
      default: ;
    endcase
  end

`ifndef LOTTO_GAUNTLET_HINT_EN
  // Comparator hint is unused when hints are disabled.
  logic unused_hint;
  assign unused_hint = ^chk_hint;
`endif

  assign guess_ready   = (state_q == PLAY);
  assign stage_idx     = stage_q;
  assign attempts_left = att_q;
  assign status        = state_q;
  assign result_valid  = rv_q;
  assign result_hit    = rh_q;
  assign hint          = hint_q;

endmodule

// File: tb/tb_lotto_gauntlet.sv
// tb/tb_lotto_gauntlet.sv - directed self-checking bench for lotto_gauntlet
module tb_lotto_gauntlet;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PLAY = 3'd1;
  localparam logic [2:0] S_VIC  = 3'd5;
  localparam logic [2:0] S_DOOM = 3'd6;

`ifdef LOTTO_GAUNTLET_HINT_EN
  localparam logic [1:0] H_LOW  = 2'b01;
  localparam logic [1:0] H_HIGH = 2'b10;
`else
  localparam logic [1:0] H_LOW  = 2'b00;
  localparam logic [1:0] H_HIGH = 2'b00;
`endif

  logic       clk;
  logic       rst;
  logic       start;
  logic       guess_valid;
  logic [7:0] guess_in;
  logic       guess_ready;
  logic [1:0] stage_idx;
  logic [1:0] attempts_left;
  lotto_pkg::status_t status;
  logic       result_valid;
  logic       result_hit;
  logic [1:0] dut_hint;

  int vec_count = 0;
  int err_count = 0;

  lotto_gauntlet #(
    .NUM_STAGES   (3),
    .GUESS_W      (8),
    .MAX_ATTEMPTS (3),
    .SECRETS      (24'h33_22_11)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .guess_valid   (guess_valid),
    .guess_in      (guess_in),
    .guess_ready   (guess_ready),
    .stage_idx     (stage_idx),
    .attempts_left (attempts_left),
    .status        (status),
    .result_valid  (result_valid),
    .result_hit    (result_hit),
    .hint          (dut_hint)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock with the given guess inputs; returns #1 after the rising edge.
  task automatic step(input logic v, input logic [7:0] g);
    guess_valid = v;
    guess_in    = g;
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step(1'b0, 8'h00);
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    #1;
  endtask

  task automatic expect_res(input string tag, input logic rh, input logic [1:0] st,
                            input logic [1:0] att, input logic [2:0] sts);
    check({tag, "_rv"}, 32'(result_valid), 32'd1);
    check({tag, "_hit"}, 32'(result_hit), 32'(rh));
    check({tag, "_stage"}, 32'(stage_idx), 32'(st));
    check({tag, "_att"}, 32'(attempts_left), 32'(att));
    check({tag, "_status"}, 32'(status), 32'(sts));
  endtask

  initial begin
    rst = 1'b0;
    start = 1'b0;
    guess_valid = 1'b0;
    guess_in = 8'h00;
    #12;
    check("rst_status", 32'(status), 32'(S_IDLE));
    check("rst_stage", 32'(stage_idx), 32'd0);
    check("rst_att", 32'(attempts_left), 32'd3);
    check("rst_ready", 32'(guess_ready), 32'd0);
    check("rst_rv", 32'(result_valid), 32'd0);
    check("rst_hint", 32'(dut_hint), 32'd0);
    rst = 1'b1;

    // Guess without start is dropped.
    step(1'b1, 8'h11);
    check("idle_ready", 32'(guess_ready), 32'd0);
    step(1'b0, 8'h00);
    check("idle_rv", 32'(result_valid), 32'd0);
    check("idle_status", 32'(status), 32'(S_IDLE));

    // start together with a guess: start only.
    start = 1'b1;
    step(1'b1, 8'h11);
    start = 1'b0;
    check("sg_status", 32'(status), 32'(S_PLAY));
    check("sg_rv", 32'(result_valid), 32'd0);
    check("sg_stage", 32'(stage_idx), 32'd0);
    check("sg_ready", 32'(guess_ready), 32'd1);

    // Victory on three back-to-back hits.
    step(1'b1, 8'h11);
    expect_res("v0", 1'b1, 2'd1, 2'd3, S_PLAY);
    step(1'b1, 8'h22);
    expect_res("v1", 1'b1, 2'd2, 2'd3, S_PLAY);
    step(1'b1, 8'h33);
    expect_res("v2", 1'b1, 2'd3, 2'd3, S_VIC);
    check("v_ready", 32'(guess_ready), 32'd0);
    start = 1'b1;
    step(1'b1, 8'h11);
    start = 1'b0;
    check("v_sticky_rv", 32'(result_valid), 32'd0);
    check("v_sticky_status", 32'(status), 32'(S_VIC));
    check("v_sticky_stage", 32'(stage_idx), 32'd3);

    // Doom after three misses on stage 0.
    do_reset();
    do_start();
    step(1'b1, 8'h05);
    expect_res("d0", 1'b0, 2'd0, 2'd2, S_PLAY);
    step(1'b1, 8'h06);
    expect_res("d1", 1'b0, 2'd0, 2'd1, S_PLAY);
    step(1'b1, 8'h07);
    expect_res("d2", 1'b0, 2'd0, 2'd0, S_DOOM);
    start = 1'b1;
    step(1'b1, 8'h11);
    start = 1'b0;
    check("d_ign_rv", 32'(result_valid), 32'd0);
    step(1'b1, 8'h11);
    check("d_ign_rv2", 32'(result_valid), 32'd0);
    check("d_ign_status", 32'(status), 32'(S_DOOM));
    check("d_ign_att", 32'(attempts_left), 32'd0);

    // Hints on stage 0, then attempts reload on a later hit.
    do_reset();
    do_start();
    step(1'b1, 8'h05);
    expect_res("h0", 1'b0, 2'd0, 2'd2, S_PLAY);
    check("h0_hint", 32'(dut_hint), 32'(H_LOW));
    step(1'b1, 8'hF0);
    expect_res("h1", 1'b0, 2'd0, 2'd1, S_PLAY);
    check("h1_hint", 32'(dut_hint), 32'(H_HIGH));
    step(1'b1, 8'h11);
    expect_res("h2", 1'b1, 2'd1, 2'd3, S_PLAY);
    check("h2_hint", 32'(dut_hint), 32'd0);
    step(1'b1, 8'h00);
    expect_res("r0", 1'b0, 2'd1, 2'd2, S_PLAY);
    check("r0_hint", 32'(dut_hint), 32'(H_LOW));
    step(1'b0, 8'h22);
    check("r_gap_rv", 32'(result_valid), 32'd0);
    check("r_gap_hint", 32'(dut_hint), 32'(H_LOW));
    step(1'b1, 8'h22);
    expect_res("r1", 1'b1, 2'd2, 2'd3, S_PLAY);

    // Asynchronous reset mid-stage 1 with one attempt left.
    do_reset();
    do_start();
    step(1'b1, 8'h11);
    step(1'b1, 8'h00);
    step(1'b1, 8'h00);
    expect_res("m0", 1'b0, 2'd1, 2'd1, S_PLAY);
    guess_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    check("m_status", 32'(status), 32'(S_IDLE));
    check("m_stage", 32'(stage_idx), 32'd0);
    check("m_att", 32'(attempts_left), 32'd3);
    check("m_rv", 32'(result_valid), 32'd0);
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
